// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared types, opcodes, headings, responses and knight move table for the tour sequencer
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE1 = 3'd1,
      WAIT1  = 3'd2,
      ISSUE2 = 3'd3,
      WAIT2  = 3'd4
   } state_t;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;
   localparam logic [7:0] HDG_W = 8'h3F;

   localparam logic [3:0] OP_MOVE    = 4'b0010;
   localparam logic [3:0] OP_FANFARE = 4'b0011;

   localparam logic [7:0] RESP_ACK   = 8'h5A;
   localparam logic [7:0] RESP_DONE  = 8'hA5;
   localparam logic [7:0] RESP_ABORT = 8'hEE;
   localparam logic [7:0] RESP_ERR   = 8'hEF;

   // Sign/magnitude form of a knight move; east and north are positive.
   typedef struct packed {
      logic       dx_neg;
      logic [1:0] dx_mag;
      logic       dy_neg;
      logic [1:0] dy_mag;
   } delta_t;

   function automatic delta_t move_delta(input logic [2:0] idx);
      delta_t d;
      case (idx)
         3'd0:    d = {1'b1, 2'd1, 1'b0, 2'd2};
         3'd1:    d = {1'b0, 2'd1, 1'b0, 2'd2};
         3'd2:    d = {1'b1, 2'd2, 1'b0, 2'd1};
         3'd3:    d = {1'b1, 2'd2, 1'b1, 2'd1};
         3'd4:    d = {1'b1, 2'd1, 1'b1, 2'd2};
         3'd5:    d = {1'b0, 2'd1, 1'b1, 2'd2};
         3'd6:    d = {1'b0, 2'd2, 1'b1, 2'd1};
         default: d = {1'b0, 2'd2, 1'b0, 2'd1};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// rtl/tour_move_decode.sv - splits a one-hot knight move into two ordered cmd_proc segments
module tour_move_decode
   import tour_pkg::*;
#(
   parameter int SEG_ORDER   = 0,
   parameter int FANFARE_SEG = 2
) (
   input  logic [7:0]  move,
   output logic [15:0] seg1_cmd,
   output logic [15:0] seg2_cmd,
   output logic        illegal
);

   logic [2:0]  idx;
   logic [3:0]  ones;
   delta_t      d;
   logic [11:0] vert_body;
   logic [11:0] horz_body;
   logic [11:0] first_body;
   logic [11:0] second_body;

   always_comb begin
      idx  = 3'd0;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (move[i]) begin
            idx  = 3'(i);
            ones = ones + 4'd1;
         end
      end
      illegal = (ones != 4'd1);

      d         = move_delta(idx);
      vert_body = {(d.dy_neg ? HDG_S : HDG_N), 2'b00, d.dy_mag};
      horz_body = {(d.dx_neg ? HDG_W : HDG_E), 2'b00, d.dx_mag};

      first_body  = (SEG_ORDER == 1) ? horz_body : vert_body;
      second_body = (SEG_ORDER == 1) ? vert_body : horz_body;

      seg1_cmd = {((FANFARE_SEG == 1) ? OP_FANFARE : OP_MOVE), first_body};
      seg2_cmd = {((FANFARE_SEG == 2) ? OP_FANFARE : OP_MOVE), second_body};
   end

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight's-tour replay sequencer muxing tour segments and UART cmds into cmd_proc
module tour_cmd_seq
   import tour_pkg::*;
#(
   parameter int NUM_MOVES   = 24,
   parameter int SEG_ORDER   = 0,
   parameter int FANFARE_SEG = 2,
   parameter int ABORT_EN    = 1,
   localparam int IDX_W      = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_tour,
   input  logic [7:0]       move,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [IDX_W-1:0] mv_indx,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   output logic [7:0]       resp,
   output logic             tour_busy
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   mv_indx_q, mv_indx_d;
   logic               cmd_rdy_tc_q, cmd_rdy_tc_d;
   logic               abort_pend_q, abort_pend_d;

   logic [15:0] seg1_cmd;
   logic [15:0] seg2_cmd;
   logic        illegal;
   logic        abort_req;
   logic        last_move;

   tour_move_decode #(
      .SEG_ORDER   (SEG_ORDER),
      .FANFARE_SEG (FANFARE_SEG)
   ) u_decode (
      .move     (move),
      .seg1_cmd (seg1_cmd),
      .seg2_cmd (seg2_cmd),
      .illegal  (illegal)
   );

   assign abort_req = (ABORT_EN != 0) && cmd_rdy_UART;
   assign last_move = (mv_indx_q == IDX_W'(NUM_MOVES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mv_indx_q    <= '0;
         cmd_rdy_tc_q <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mv_indx_q    <= mv_indx_d;
         cmd_rdy_tc_q <= cmd_rdy_tc_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   // cmd_rdy_tc is raised on the transition into an ISSUE state so the request
   // is visible in the first ISSUE cycle; clr_cmd_rdy always overrides the set.
   always_comb begin
      state_d      = state_q;
      mv_indx_d    = mv_indx_q;
      cmd_rdy_tc_d = cmd_rdy_tc_q;
      abort_pend_d = abort_pend_q;
      resp         = RESP_ACK;

      if (state_q != IDLE && abort_req) begin
         abort_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cmd_rdy_tc_d = 1'b0;
            if (start_tour) begin
               mv_indx_d    = '0;
               abort_pend_d = 1'b0;
               cmd_rdy_tc_d = 1'b1;
               state_d      = ISSUE1;
            end
         end
         ISSUE1: begin
            if (illegal) begin
               cmd_rdy_tc_d = 1'b0;
               resp         = RESP_ERR;
               state_d      = IDLE;
            end else if (clr_cmd_rdy) begin
               cmd_rdy_tc_d = 1'b0;
               state_d      = WAIT1;
            end else begin
               cmd_rdy_tc_d = 1'b1;
            end
         end
         WAIT1: begin
            cmd_rdy_tc_d = 1'b0;
            if (send_resp) begin
               cmd_rdy_tc_d = 1'b1;
               state_d      = ISSUE2;
            end
         end
         ISSUE2: begin
            cmd_rdy_tc_d = !clr_cmd_rdy;
            if (clr_cmd_rdy) begin
               state_d = WAIT2;
            end
         end
         WAIT2: begin
            cmd_rdy_tc_d = 1'b0;
            if (send_resp) begin
               if (abort_pend_q || abort_req) begin
                  resp    = RESP_ABORT;
                  state_d = IDLE;
               end else if (last_move) begin
                  resp    = RESP_DONE;
                  state_d = IDLE;
               end else begin
                  mv_indx_d    = mv_indx_q + IDX_W'(1);
                  cmd_rdy_tc_d = 1'b1;
                  state_d      = ISSUE1;
               end
            end
         end
         default: begin
            cmd_rdy_tc_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // An illegal move must never raise cmd_rdy, even in the ISSUE1 cycle that detects it.
   always_comb begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
      case (state_q)
         IDLE: begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
         end
         ISSUE1, WAIT1: begin
            cmd     = seg1_cmd;
            cmd_rdy = cmd_rdy_tc_q && !(state_q == ISSUE1 && illegal);
         end
         default: begin
            cmd     = seg2_cmd;
            cmd_rdy = cmd_rdy_tc_q;
         end
      endcase
   end

   assign mv_indx   = mv_indx_q;
   assign tour_busy = (state_q != IDLE);

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - self-checking bench for tour_cmd_seq with a move-table reference model
module tb_tour_cmd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour, a_start;
   logic        cmd_rdy_UART, clr_cmd_rdy, send_resp;
   logic [15:0] cmd_UART;
   logic [7:0]  move_tbl [32];
   logic [7:0]  move;
   logic [7:0]  a_move;

   logic [4:0]  mv_indx;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;
   logic        tour_busy;

   logic [0:0]  a_mv_indx;
   logic [15:0] a_cmd;
   logic        a_cmd_rdy;
   logic [7:0]  a_resp;
   logic        a_tour_busy;

   bit          sel;
   logic [15:0] o_cmd;
   logic        o_cmd_rdy, o_busy;
   logic [7:0]  o_resp;

   int n_cmp = 0;
   int n_bad = 0;

   int dx_tbl [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
   int dy_tbl [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

   always #5 clk = ~clk;

   assign move   = move_tbl[mv_indx];
   assign a_move = 8'h80;
   assign o_cmd     = sel ? a_cmd : cmd;
   assign o_cmd_rdy = sel ? a_cmd_rdy : cmd_rdy;
   assign o_resp    = sel ? a_resp : resp;
   assign o_busy    = sel ? a_tour_busy : tour_busy;

   tour_cmd_seq u_dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
      .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .mv_indx(mv_indx), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .resp(resp), .tour_busy(tour_busy)
   );

   tour_cmd_seq #(.NUM_MOVES(1), .SEG_ORDER(1), .FANFARE_SEG(1), .ABORT_EN(0)) u_alt (
      .clk(clk), .rst_n(rst_n), .start_tour(a_start), .move(a_move),
      .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .mv_indx(a_mv_indx), .cmd(a_cmd), .cmd_rdy(a_cmd_rdy),
      .resp(a_resp), .tour_busy(a_tour_busy)
   );

   // Expected segment command from the knight displacement of the single set bit.
   function automatic logic [15:0] exp_seg(input logic [7:0] mv, input int seg,
                                           input int order, input int fan);
      int b, dx, dy, n;
      bit horiz;
      logic [7:0] hdg;
      b = 0;
      for (int i = 0; i < 8; i++) if (mv[i]) b = i;
      dx = dx_tbl[b];
      dy = dy_tbl[b];
      horiz = (seg == 1) ? (order == 1) : (order == 0);
      if (horiz) begin
         n   = (dx < 0) ? -dx : dx;
         hdg = (dx > 0) ? 8'hBF : 8'h3F;
      end else begin
         n   = (dy < 0) ? -dy : dy;
         hdg = (dy > 0) ? 8'h00 : 8'h7F;
      end
      return {((fan == seg) ? 4'h3 : 4'h2), hdg, n[3:0]};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) move_tbl[i] = 8'h01 << $urandom_range(7, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; start_tour = 1'b0; a_start = 1'b0;
      cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start_tour = 1'b1;
      @(negedge clk);
      start_tour = 1'b0;
   endtask

   // Called on the negedge where cmd_rdy must already be high; returns on the
   // negedge after send_resp. pulse: 0 none, 1 UART cmd in WAIT, 2 start_tour in WAIT.
   task automatic serve_cmd(input logic [15:0] exp, input string nm, input int pulse,
                            output logic [7:0] r);
      n_cmp++;
      if (o_cmd_rdy !== 1'b1) begin
         n_bad++; $display("FAIL %s_rdy: cmd_rdy=%b expected 1", nm, o_cmd_rdy);
      end
      n_cmp++;
      if (o_cmd !== exp) begin
         n_bad++; $display("FAIL %s_cmd: cmd=%h expected %h", nm, o_cmd, exp);
      end
      repeat (2) @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      n_cmp++;
      if (o_cmd_rdy !== 1'b0) begin
         n_bad++; $display("FAIL %s_clr: cmd_rdy=%b expected 0", nm, o_cmd_rdy);
      end
      if (pulse == 1) begin
         cmd_UART = ~exp;
         cmd_rdy_UART = 1'b1;
         #1;
         n_cmp++;
         if (o_cmd !== exp || o_cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_no_fwd: cmd=%h rdy=%b expected %h/0", nm, o_cmd, o_cmd_rdy, exp);
         end
      end else if (pulse == 2) begin
         start_tour = 1'b1;
      end
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j == 0 && pulse != 0) begin
            cmd_rdy_UART = 1'b0;
            start_tour = 1'b0;
            n_cmp++;
            if (o_cmd_rdy !== 1'b0 || o_busy !== 1'b1) begin
               n_bad++;
               $display("FAIL %s_pulse: cmd_rdy=%b busy=%b expected 0/1", nm, o_cmd_rdy, o_busy);
            end
         end
      end
      send_resp = 1'b1;
      #1 r = o_resp;
      @(negedge clk);
      send_resp = 1'b0;
   endtask

   task automatic serve_move(input int i, input int pulse, input logic [7:0] exp_end);
      logic [7:0] r;
      n_cmp++;
      if (mv_indx !== 5'(i)) begin
         n_bad++; $display("FAIL mv_indx_move%0d: got %0d expected %0d", i, mv_indx, i);
      end
      serve_cmd(exp_seg(move_tbl[i], 1, 0, 2), $sformatf("m%0d_s1", i), pulse, r);
      n_cmp++;
      if (r !== 8'h5A) begin
         n_bad++; $display("FAIL m%0d_resp1: resp=%h expected 5a", i, r);
      end
      serve_cmd(exp_seg(move_tbl[i], 2, 0, 2), $sformatf("m%0d_s2", i), 0, r);
      n_cmp++;
      if (r !== exp_end) begin
         n_bad++; $display("FAIL m%0d_resp2: resp=%h expected %h", i, r, exp_end);
      end
   endtask

   task automatic test_reset();
      cmd_UART = 16'($urandom);
      apply_reset();
      n_cmp++;
      if (mv_indx !== 5'd0 || cmd !== cmd_UART || cmd_rdy !== 1'b0 ||
          resp !== 8'h5A || tour_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: mv=%0d cmd=%h rdy=%b resp=%h busy=%b expected 0/%h/0/5a/0",
                  mv_indx, cmd, cmd_rdy, resp, tour_busy, cmd_UART);
      end
   endtask

   task automatic test_passthrough();
      for (int k = 0; k < 8; k++) begin
         cmd_UART = 16'($urandom);
         cmd_rdy_UART = 1'($urandom);
         #1;
         n_cmp++;
         if (cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART || resp !== 8'h5A) begin
            n_bad++;
            $display("FAIL pass%0d: cmd=%h rdy=%b resp=%h expected %h/%b/5a",
                     k, cmd, cmd_rdy, resp, cmd_UART, cmd_rdy_UART);
         end
         @(negedge clk);
      end
      cmd_rdy_UART = 1'b0;
   endtask

   task automatic test_full_tour();
      fill_random();
      move_tbl[0] = 8'h01;
      apply_reset();
      pulse_start();
      n_cmp++;
      if (cmd !== 16'h2002) begin
         n_bad++; $display("FAIL tour_first_cmd: cmd=%h expected 2002", cmd);
      end
      for (int i = 0; i < 24; i++) serve_move(i, 0, (i == 23) ? 8'hA5 : 8'h5A);
      cmd_UART = 16'($urandom);
      #1;
      n_cmp++;
      if (tour_busy !== 1'b0 || resp !== 8'h5A || cmd !== cmd_UART) begin
         n_bad++;
         $display("FAIL tour_end: busy=%b resp=%h cmd=%h expected 0/5a/%h",
                  tour_busy, resp, cmd, cmd_UART);
      end
   endtask

   task automatic test_abort();
      fill_random();
      apply_reset();
      pulse_start();
      for (int i = 0; i < 5; i++) serve_move(i, 0, 8'h5A);
      serve_move(5, 1, 8'hEE);
      n_cmp++;
      if (tour_busy !== 1'b0 || mv_indx !== 5'd5) begin
         n_bad++;
         $display("FAIL abort_end: busy=%b mv=%0d expected 0/5", tour_busy, mv_indx);
      end
   endtask

   task automatic test_illegal();
      fill_random();
      move_tbl[0] = 8'h03;
      apply_reset();
      pulse_start();
      n_cmp++;
      if (cmd_rdy !== 1'b0 || resp !== 8'hEF) begin
         n_bad++; $display("FAIL illegal0: rdy=%b resp=%h expected 0/ef", cmd_rdy, resp);
      end
      @(negedge clk);
      n_cmp++;
      if (cmd_rdy !== 1'b0 || resp !== 8'h5A || tour_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal0_after: rdy=%b resp=%h busy=%b expected 0/5a/0",
                  cmd_rdy, resp, tour_busy);
      end
      fill_random();
      move_tbl[2] = 8'h00;
      apply_reset();
      pulse_start();
      serve_move(0, 0, 8'h5A);
      serve_move(1, 0, 8'h5A);
      n_cmp++;
      if (cmd_rdy !== 1'b0 || resp !== 8'hEF || mv_indx !== 5'd2) begin
         n_bad++;
         $display("FAIL illegal2: rdy=%b resp=%h mv=%0d expected 0/ef/2", cmd_rdy, resp, mv_indx);
      end
      @(negedge clk);
      n_cmp++;
      if (tour_busy !== 1'b0 || mv_indx !== 5'd2 || resp !== 8'h5A) begin
         n_bad++;
         $display("FAIL illegal2_after: busy=%b mv=%0d resp=%h expected 0/2/5a",
                  tour_busy, mv_indx, resp);
      end
   endtask

   task automatic test_restart_reset();
      logic [7:0] r;
      fill_random();
      apply_reset();
      pulse_start();
      serve_move(0, 0, 8'h5A);
      serve_cmd(exp_seg(move_tbl[1], 1, 0, 2), "restart_s1", 2, r);
      n_cmp++;
      if (mv_indx !== 5'd1 || cmd_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_ignored: mv=%0d rdy=%b expected 1/1", mv_indx, cmd_rdy);
      end
      repeat (2) @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      repeat (3) @(negedge clk);
      cmd_UART = 16'($urandom);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (tour_busy !== 1'b0 || cmd !== cmd_UART || mv_indx !== 5'd0 ||
          resp !== 8'h5A || cmd_rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_wait2: busy=%b cmd=%h mv=%0d resp=%h rdy=%b expected 0/%h/0/5a/0",
                  tour_busy, cmd, mv_indx, resp, cmd_rdy, cmd_UART);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alt_single_move();
      logic [7:0] r;
      int stray;
      apply_reset();
      sel = 1'b1;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      n_cmp++;
      if (a_cmd !== 16'h3BF2) begin
         n_bad++; $display("FAIL alt_first_cmd: cmd=%h expected 3bf2", a_cmd);
      end
      serve_cmd(exp_seg(8'h80, 1, 1, 1), "alt_s1", 1, r);
      n_cmp++;
      if (r !== 8'h5A) begin
         n_bad++; $display("FAIL alt_resp1: resp=%h expected 5a", r);
      end
      n_cmp++;
      if (a_cmd !== 16'h2001 || a_mv_indx !== 1'b0) begin
         n_bad++; $display("FAIL alt_second_cmd: cmd=%h mv=%0d expected 2001/0", a_cmd, a_mv_indx);
      end
      serve_cmd(exp_seg(8'h80, 2, 1, 1), "alt_s2", 0, r);
      n_cmp++;
      if (r !== 8'hA5) begin
         n_bad++; $display("FAIL alt_done: resp=%h expected a5", r);
      end
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         if (a_cmd_rdy !== 1'b0 || a_tour_busy !== 1'b0) stray++;
         @(negedge clk);
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++; $display("FAIL alt_extra_cmds: %0d busy/rdy cycles expected 0", stray);
      end
      cmd_UART = 16'h1234;
      #1;
      n_cmp++;
      if (a_cmd !== 16'h1234) begin
         n_bad++; $display("FAIL alt_passthrough: cmd=%h expected 1234", a_cmd);
      end
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      rst_n = 1'b0; start_tour = 1'b0; a_start = 1'b0;
      cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      cmd_UART = 16'h0;
      fill_random();
      test_reset();
      test_passthrough();
      test_full_tour();
      test_abort();
      test_illegal();
      test_restart_reset();
      test_alt_single_move();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
      $fatal(1);
   end

endmodule
